// File: rtl/core_pkg.sv
// core_pkg: datapath width and opcode encodings shared by the execute-stage units.
//   DATA_WIDTH        operand/result width
//   ALU_WIDTH_CODE    width of the ALU opcode field
//   SHIFT_WIDTH_CODE  width of the shifter opcode field
package core_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int ALU_WIDTH_CODE   = 4;
    localparam int SHIFT_WIDTH_CODE = 2;

    localparam logic [ALU_WIDTH_CODE-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_WIDTH_CODE-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_WIDTH_CODE-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_WIDTH_CODE-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_WIDTH_CODE-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_WIDTH_CODE-1:0] ALU_SLT  = 4'd5;
    localparam logic [ALU_WIDTH_CODE-1:0] ALU_SLTU = 4'd6;

    localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_SLL = 2'd0;
    localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_SRL = 2'd1;
    localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_SRA = 2'd2;

endpackage

// File: rtl/exec_unit_pkg.sv
// exec_unit_pkg: unit selection, multiplier control and FSM state types for
// core_execution_unit.
package exec_unit_pkg;

    localparam int EX_UNIT_WIDTH = 2;

    typedef enum logic [EX_UNIT_WIDTH-1:0] {
        EX_UNIT_ALU   = 2'd0,
        EX_UNIT_SHIFT = 2'd1,
        EX_UNIT_MUL   = 2'd2
    } ex_unit_e;

    // Encoding 3 is not a unit; it produces a zero result flagged with out_err.
    localparam logic [EX_UNIT_WIDTH-1:0] EX_UNIT_ILLEGAL = 2'd3;

    typedef enum logic {
        MUL_LO = 1'b0,
        MUL_HU = 1'b1
    } mul_ctrl_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/core_alu.sv
// core_alu: combinational integer ALU.
//   alu_a, alu_b  operands
//   alu_control   opcode (core_pkg ALU_*)
//   alu_result    result; unknown opcodes give 0
module core_alu
    import core_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0]          alu_a,
    input  logic [WIDTH-1:0]          alu_b,
    input  logic [ALU_WIDTH_CODE-1:0] alu_control,
    output logic [WIDTH-1:0]          alu_result
);

    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_SLT:  alu_result = WIDTH'($signed(alu_a) < $signed(alu_b));
            ALU_SLTU: alu_result = WIDTH'(alu_a < alu_b);
            default:  alu_result = '0;
        endcase
    end

endmodule

// File: rtl/core_mul_iter.sv
// core_mul_iter: iterative unsigned shift-and-add multiplier.
//   clk, rst    clock, synchronous active-high reset
//   kill        abandons the current multiply
//   start       loads operands and begins DATA_WIDTH/BITS_PER_CYCLE iterations
//   mul_op      MUL_LO selects the low half of the product, MUL_HU the high half
//   mul_a/mul_b multiplicand / multiplier
//   done        high during the last iteration; mul_result is valid alongside it
//   mul_result  selected half of the completed product
module core_mul_iter
    import exec_unit_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kill,
    input  logic                  start,
    input  mul_ctrl_e             mul_op,
    input  logic [DATA_WIDTH-1:0] mul_a,
    input  logic [DATA_WIDTH-1:0] mul_b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] mul_result
);

    localparam int unsigned STEPS = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int          CW    = $clog2(STEPS + 1);

    logic [CW-1:0]           count;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] acc_next;
    logic [2*DATA_WIDTH-1:0] partial;
    // Multiplicand is pre-shifted each iteration so the partial product
    // always lands at the current bit position.
    logic [2*DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0]   mplier;
    mul_ctrl_e               op_q;

    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) partial = partial + (mcand << i);
        end
        acc_next = acc + partial;
    end

    // The final accumulation is forwarded so the result register in the
    // parent loads on the same edge the counter reaches zero.
    assign done       = (count == CW'(1));
    assign mul_result = (op_q == MUL_HU) ? acc_next[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : acc_next[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            op_q   <= MUL_LO;
        end else if (kill) begin
            count <= '0;
        end else if (start) begin
            count  <= CW'(STEPS);
            acc    <= '0;
            mcand  <= {{DATA_WIDTH{1'b0}}, mul_a};
            mplier <= mul_b;
            op_q   <= mul_op;
        end else if (count != '0) begin
            count  <= count - CW'(1);
            acc    <= acc_next;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
        end
    end

endmodule

// File: rtl/core_shift.sv
// core_shift: combinational barrel shifter.
//   shift_a        value to shift
//   shift_b        shift amount taken from the low log2(WIDTH) bits
//   shift_control  opcode (core_pkg SHIFT_*)
//   shift_result   result; unknown opcodes give 0
module core_shift
    import core_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0]            shift_a,
    input  logic [WIDTH-1:0]            shift_b,
    input  logic [SHIFT_WIDTH_CODE-1:0] shift_control,
    output logic [WIDTH-1:0]            shift_result
);

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0] shamt;
    assign shamt = shift_b[SW-1:0];

    always_comb begin
        shift_result = '0;
        case (shift_control)
            SHIFT_SLL: shift_result = shift_a << shamt;
            SHIFT_SRL: shift_result = shift_a >> shamt;
            SHIFT_SRA: shift_result = $unsigned($signed(shift_a) >>> shamt);
            default:   shift_result = '0;
        endcase
    end

endmodule

// File: rtl/core_execution_unit.sv
// core_execution_unit: registered execute stage with valid/ready handshakes.
//   clk, rst, flush          clock, sync active-high reset, sync kill of in-flight work
//   in_valid/in_ready        input handshake; one op accepted per handshake
//   unit_sel                 ALU / SHIFT / MUL; encoding 3 returns 0 with out_err
//   alu_control, shift_control, mul_control  per-unit opcodes
//   ex_in_a, ex_in_b, in_tag operands and destination tag
//   out_valid/out_ready      output handshake; result held while stalled
//   ex_out, out_tag, out_err result, its tag, illegal-unit flag
//   busy                     multiplier iterating
module core_execution_unit
    import exec_unit_pkg::*;
#(
    parameter int          DATA_WIDTH         = core_pkg::DATA_WIDTH,
    parameter int          TAG_WIDTH          = 5,
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [EX_UNIT_WIDTH-1:0]              unit_sel,
    input  logic [core_pkg::ALU_WIDTH_CODE-1:0]   alu_control,
    input  logic [core_pkg::SHIFT_WIDTH_CODE-1:0] shift_control,
    input  logic                                  mul_control,
    input  logic [DATA_WIDTH-1:0]                 ex_in_a,
    input  logic [DATA_WIDTH-1:0]                 ex_in_b,
    input  logic [TAG_WIDTH-1:0]                  in_tag,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 ex_out,
    output logic [TAG_WIDTH-1:0]                  out_tag,
    output logic                                  out_err,
    output logic                                  busy
);

    if (DATA_WIDTH % MUL_BITS_PER_CYCLE != 0) begin : g_bad_mul_cfg
        $fatal(1, "core_execution_unit: MUL_BITS_PER_CYCLE must divide DATA_WIDTH");
    end

    state_e                state;
    logic                  accept;
    logic                  mul_start;
    logic                  mul_done;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] shift_result;
    logic [DATA_WIDTH-1:0] mul_result;
    logic [DATA_WIDTH-1:0] comb_result;
    logic [TAG_WIDTH-1:0]  mul_tag;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (unit_sel == EX_UNIT_MUL);

    core_alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .alu_a       (ex_in_a),
        .alu_b       (ex_in_b),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    core_shift #(.WIDTH(DATA_WIDTH)) u_shift (
        .shift_a       (ex_in_a),
        .shift_b       (ex_in_b),
        .shift_control (shift_control),
        .shift_result  (shift_result)
    );

    core_mul_iter #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk        (clk),
        .rst        (rst),
        .kill       (flush),
        .start      (mul_start),
        .mul_op     (mul_ctrl_e'(mul_control)),
        .mul_a      (ex_in_a),
        .mul_b      (ex_in_b),
        .done       (mul_done),
        .mul_result (mul_result)
    );

    always_comb begin
        comb_result = '0;
        case (unit_sel)
            EX_UNIT_ALU:   comb_result = alu_result;
            EX_UNIT_SHIFT: comb_result = shift_result;
            default:       comb_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            ex_out    <= '0;
            out_tag   <= '0;
            mul_tag   <= '0;
        end else if (flush) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            // A new result loaded here overrides the drain above.
            if (accept) begin
                if (unit_sel == EX_UNIT_MUL) begin
                    state   <= MUL;
                    busy    <= 1'b1;
                    mul_tag <= in_tag;
                end else begin
                    out_valid <= 1'b1;
                    ex_out    <= comb_result;
                    out_tag   <= in_tag;
                    out_err   <= (unit_sel == EX_UNIT_ILLEGAL);
                end
            end
            // No accept happens in MUL, so the output slot is free here.
            if (state == MUL && mul_done) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b1;
                ex_out    <= mul_result;
                out_tag   <= mul_tag;
                out_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_execution_unit.sv
// Directed testbench for core_execution_unit with a scoreboard of expected results.
module tb_core_execution_unit;
    import core_pkg::*;
    import exec_unit_pkg::*;

    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_valid4, out_ready, out_ready4, mul_control;
    logic [1:0]    unit_sel;
    logic [3:0]    alu_control;
    logic [1:0]    shift_control;
    logic [W-1:0]  ex_in_a, ex_in_b;
    logic [TW-1:0] in_tag;
    logic          in_ready, out_valid, out_err, busy;
    logic [W-1:0]  ex_out;
    logic [TW-1:0] out_tag;
    logic          in_ready4, out_valid4, out_err4, busy4;
    logic [W-1:0]  ex_out4;
    logic [TW-1:0] out_tag4;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    core_execution_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .unit_sel(unit_sel), .alu_control(alu_control), .shift_control(shift_control),
        .mul_control(mul_control), .ex_in_a(ex_in_a), .ex_in_b(ex_in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .ex_out(ex_out), .out_tag(out_tag),
        .out_err(out_err), .busy(busy)
    );

    core_execution_unit #(.MUL_BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid4), .in_ready(in_ready4),
        .unit_sel(unit_sel), .alu_control(alu_control), .shift_control(shift_control),
        .mul_control(mul_control), .ex_in_a(ex_in_a), .ex_in_b(ex_in_b), .in_tag(in_tag),
        .out_valid(out_valid4), .out_ready(out_ready4), .ex_out(ex_out4), .out_tag(out_tag4),
        .out_err(out_err4), .busy(busy4)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] us, input logic [3:0] ac, input logic [1:0] sc,
                                   input logic mc, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [TW-1:0] tag);
        exp_t        r;
        logic [63:0] p;
        r.data = '0;
        r.tag  = tag;
        r.err  = 1'b0;
        p = {32'd0, a} * {32'd0, b};
        case (us)
            2'd0: begin
                if (ac == ALU_ADD)       r.data = a + b;
                else if (ac == ALU_SUB)  r.data = a - b;
                else if (ac == ALU_XOR)  r.data = a ^ b;
                else if (ac == ALU_SLTU) r.data = (a < b) ? 32'd1 : 32'd0;
            end
            2'd1: begin
                if (sc == SHIFT_SLL)      r.data = a << b[4:0];
                else if (sc == SHIFT_SRL) r.data = a >> b[4:0];
                else if (sc == SHIFT_SRA) r.data = $unsigned($signed(a) >>> b[4:0]);
            end
            2'd2:    r.data = mc ? p[63:32] : p[31:0];
            default: r.err  = 1'b1;
        endcase
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] us, input logic [3:0] ac, input logic [1:0] sc,
                        input logic mc, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input bit push);
        int unsigned n = 0;
        unit_sel = us; alu_control = ac; shift_control = sc; mul_control = mc;
        ex_in_a = a; ex_in_b = b; in_tag = tag; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 200) check("accept_timeout", 64'(n), 0);
        if (push) sb.push_back(model(us, ac, sc, mc, a, b, tag));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: every completed output transfer must match the next expected result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {32'd0, ex_out}, 64'hDEAD);
            end else begin
                e = sb.pop_front();
                check("sb_data", 64'(ex_out), 64'(e.data));
                check("sb_tag", 64'(out_tag), 64'(e.tag));
                check("sb_err", 64'(out_err), 64'(e.err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        int          c0;
        int          leaks;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0;
        out_ready = 1'b1; out_ready4 = 1'b1; mul_control = 1'b0;
        unit_sel = '0; alu_control = '0; shift_control = '0;
        ex_in_a = '0; ex_in_b = '0; in_tag = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_ex_out", 64'(ex_out), 0);
        check("rst_out_tag", 64'(out_tag), 0);
        check("rst_out_err", 64'(out_err), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 1);
        @(posedge clk); #1;

        // ALU_ADD 5+7, latency 1
        send(2'd0, ALU_ADD, SHIFT_SLL, 1'b0, 32'd5, 32'd7, 5'd3, 1'b1);
        check("add_valid", 64'(out_valid), 1);
        check("add_data", 64'(ex_out), 12);
        check("add_tag", 64'(out_tag), 3);
        check("add_err", 64'(out_err), 0);

        // 10 back-to-back ALU/SHIFT ops, one per cycle
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            int unsigned sel;
            logic [W-1:0] a, b;
            sel = $urandom_range(0, 5);
            a = $urandom;
            b = $urandom;
            case (sel)
                0: send(2'd0, ALU_ADD, SHIFT_SLL, 1'b0, a, b, TW'(i), 1'b1);
                1: send(2'd0, ALU_SUB, SHIFT_SLL, 1'b0, a, b, TW'(i), 1'b1);
                2: send(2'd0, ALU_XOR, SHIFT_SLL, 1'b0, a, b, TW'(i), 1'b1);
                3: send(2'd0, ALU_SLTU, SHIFT_SLL, 1'b0, a, b, TW'(i), 1'b1);
                4: send(2'd1, ALU_ADD, SHIFT_SRL, 1'b0, a, b, TW'(i), 1'b1);
                default: send(2'd1, ALU_ADD, SHIFT_SRA, 1'b0, a, b, TW'(i), 1'b1);
            endcase
        end
        check("b2b_cycles", 64'(cyc - c0), 10);
        @(negedge clk); #1;
        check("b2b_drained", 64'(sb.size()), 0);
        @(posedge clk); #1;

        // SHIFT_SLL 1<<31 with output stall
        out_ready = 1'b0;
        send(2'd1, ALU_ADD, SHIFT_SLL, 1'b0, 32'd1, 32'd31, 5'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", 64'(out_valid), 1);
            check("stall_data", 64'(ex_out), 64'h8000_0000);
            check("stall_tag", 64'(out_tag), 4);
            check("stall_in_ready", 64'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_valid", 64'(out_valid), 0);

        // MUL_LO max*max, 1 bit per cycle
        send(2'd2, ALU_ADD, SHIFT_SLL, MUL_LO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1);
        check("mul_busy", 64'(busy), 1);
        check("mul_in_ready", 64'(in_ready), 0);
        k = 0;
        while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
        check("mul_lo_latency", 64'(k), 32);
        check("mul_lo_data", 64'(ex_out), 1);
        check("mul_done_busy", 64'(busy), 0);
        @(posedge clk); #1;

        // MUL_HU max*max
        send(2'd2, ALU_ADD, SHIFT_SLL, MUL_HU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1);
        k = 0;
        while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
        check("mul_hu_latency", 64'(k), 32);
        check("mul_hu_data", 64'(ex_out), 64'hFFFF_FFFE);
        @(posedge clk); #1;

        // 4 bits per cycle instance
        unit_sel = EX_UNIT_MUL; mul_control = MUL_LO;
        ex_in_a = 32'hFFFF_FFFF; ex_in_b = 32'hFFFF_FFFF; in_tag = 5'd8;
        in_valid4 = 1'b1;
        #1;
        check("mul4_in_ready", 64'(in_ready4), 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        k = 0;
        while (!out_valid4 && k < 100) begin @(posedge clk); #1; k++; end
        check("mul4_latency", 64'(k), 8);
        check("mul4_data", 64'(ex_out4), 1);
        check("mul4_tag", 64'(out_tag4), 8);

        // MUL 0x1234*0x10 flushed at iteration 10
        send(2'd2, ALU_ADD, SHIFT_SLL, MUL_LO, 32'h1234, 32'h10, 5'd10, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 0);
        check("flush_valid", 64'(out_valid), 0);
        leaks = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) leaks++;
            @(posedge clk); #1;
        end
        check("flush_no_result", 64'(leaks), 0);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 0);
        flush = 1'b0;
        #1;
        send(2'd0, ALU_SUB, SHIFT_SLL, 1'b0, 32'd100, 32'd1, 5'd17, 1'b1);
        check("post_flush_tag", 64'(out_tag), 17);
        check("post_flush_data", 64'(ex_out), 99);

        // Illegal unit select
        send(2'd3, ALU_ADD, SHIFT_SLL, 1'b0, 32'h55, 32'h66, 5'd9, 1'b1);
        check("illegal_valid", 64'(out_valid), 1);
        check("illegal_data", 64'(ex_out), 0);
        check("illegal_err", 64'(out_err), 1);
        check("illegal_tag", 64'(out_tag), 9);
        @(posedge clk); #1;

        // Reset mid-MUL
        send(2'd0, ALU_ADD, SHIFT_SLL, 1'b0, 32'd20, 32'd22, 5'd11, 1'b1);
        send(2'd2, ALU_ADD, SHIFT_SLL, MUL_LO, 32'h77, 32'h99, 5'd12, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmul_busy", 64'(busy), 0);
        check("rstmul_valid", 64'(out_valid), 0);
        check("rstmul_ex_out", 64'(ex_out), 0);
        check("rstmul_tag", 64'(out_tag), 0);
        rst = 1'b0;
        #1;
        check("rstmul_in_ready", 64'(in_ready), 1);
        leaks = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) leaks++;
            @(posedge clk); #1;
        end
        check("rstmul_no_result", 64'(leaks), 0);

        // Reset while a result is held
        out_ready = 1'b0;
        send(2'd3, ALU_ADD, SHIFT_SLL, 1'b0, 32'h11, 32'h22, 5'd21, 1'b1);
        @(posedge clk); #1;
        check("hold_valid", 64'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rsthold_valid", 64'(out_valid), 0);
        check("rsthold_tag", 64'(out_tag), 0);
        check("rsthold_err", 64'(out_err), 0);
        sb.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rsthold_in_ready", 64'(in_ready), 1);

        // Normal operation after reset
        send(2'd0, ALU_XOR, SHIFT_SLL, 1'b0, 32'hF0F0_0000, 32'h0FF0_1234, 5'd30, 1'b1);
        check("final_data", 64'(ex_out), 64'hFF00_1234);
        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_execution_unit.md
Name: core_execution_unit

Overview:
- Sequential successor to the combinational execution stage; accepts one operation per handshake and returns a registered result with a tag.
- Routes operands to the existing core_alu and core_shift, both combinational with 1-cycle latency.
- Adds an iterative multiplier with parametrised radix, a valid/ready handshake on both sides, and a pipeline flush.
- Sits between decode/operand-read and writeback.

Parameters:
DATA_WIDTH, 32, operand/result width (default taken from core_pkg).
TAG_WIDTH, 5, destination tag carried with each operation (rd index).
MUL_BITS_PER_CYCLE, 1, multiplier bits consumed per iteration; must divide DATA_WIDTH.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of in-flight and pending work
in_valid  in  1  operation present
in_ready  out  1  unit can accept this cycle
unit_sel  in  2  EX_UNIT_ALU / EX_UNIT_SHIFT / EX_UNIT_MUL; 3 is illegal
alu_control  in  ALU_WIDTH_CODE  ALU opcode
shift_control  in  SHIFT_WIDTH_CODE  shifter opcode
mul_control  in  1  MUL_LO (low half) / MUL_HU (high half, unsigned)
ex_in_a  in  DATA_WIDTH  operand A (multiplicand)
ex_in_b  in  DATA_WIDTH  operand B (multiplier)
in_tag  in  TAG_WIDTH  tag
out_valid  out  1  result present
out_ready  in  1  consumer accepts
ex_out  out  DATA_WIDTH  result
out_tag  out  TAG_WIDTH  tag of result
out_err  out  1  result came from illegal unit_sel
busy  out  1  multiplier iterating

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; out_valid, out_err, busy = 0; ex_out, out_tag = 0; iteration counter = 0.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept happens when in_valid && in_ready.
- ALU, SHIFT or illegal op accepted: on the next edge, out_valid=1, ex_out=core_alu/core_shift output or 0, out_tag=in_tag, out_err=(unit_sel==3). Latency 1; back-to-back throughput of 1/cycle.
- MUL op accepted:
  - On accept: state->MUL, busy=1; latch A, B, mul_control and tag; clear the 2*DATA_WIDTH accumulator; load counter N = DATA_WIDTH/MUL_BITS_PER_CYCLE.
  - Each MUL cycle: add A * (low MUL_BITS_PER_CYCLE bits of B), shifted to the current bit position, into the accumulator; shift B right by MUL_BITS_PER_CYCLE; decrement counter.
  - On the edge where the counter reaches 0: state->IDLE, busy=0, out_valid=1, ex_out = low or high DATA_WIDTH bits of the accumulator, out_err=0.
  - out_valid rises exactly N edges after the accept edge.
- The output slot is guaranteed empty on MUL completion, because accept required the slot to be free or draining and no accept occurs during MUL.
- Output hold: while out_valid && !out_ready, ex_out, out_tag and out_err are stable. out_valid clears on out_ready unless a new result is loaded on the same edge.
- Arithmetic is modulo 2^(2*DATA_WIDTH). Operands are treated as unsigned. 0*x=0. Max*max gives high = 2^W-2 and low = 1.
- Flush, single cycle, priority over everything except rst:
  - out_valid=0; aborts MUL (state->IDLE, busy=0); no accept that cycle.
  - Results and stale accumulator contents never appear after the flush.
- Reset mid-MUL behaves identically to flush, plus all registers return to their reset values.
- in_valid is ignored while in_ready=0; the upstream stage holds its operands stable.
- Simultaneous out_ready drain and new accept on the same edge: the new result replaces the old one with no bubble.
- Elaboration check: DATA_WIDTH % MUL_BITS_PER_CYCLE != 0 is a fatal error.

Decomposition:
- New package exec_unit_pkg contains:
  - enum ex_unit_e {EX_UNIT_ALU=0, EX_UNIT_SHIFT=1, EX_UNIT_MUL=2}
  - enum mul_ctrl_e {MUL_LO=0, MUL_HU=1}
  - enum state_e {IDLE, MUL}
  - EX_UNIT_WIDTH = 2
- DATA_WIDTH stays in core_pkg.
- Sub-module core_mul_iter holds the counter, accumulator and multiplier shift register, with a start/done interface.
- core_execution_unit holds the handshake, output register and mux, and reuses core_alu and core_shift unchanged.

Test Plan:
- ALU_ADD, A=5, B=7, tag=3, out_ready=1 -> next cycle out_valid=1, ex_out=12, out_tag=3, out_err=0; 10 back-to-back ops give 10 results in 10 cycles.
- SHIFT_SLL, A=1, B=31 -> ex_out=0x8000_0000. Hold out_ready=0 for 4 cycles -> output stable, in_ready=0; release -> drains.
- MUL_LO, A=0xFFFF_FFFF, B=0xFFFF_FFFF, MUL_BITS_PER_CYCLE=1 -> out_valid exactly 32 edges after accept, ex_out=1. Same operands with MUL_HU -> 0xFFFF_FFFE. With MUL_BITS_PER_CYCLE=4 -> latency 8.
- MUL 0x1234*0x10 accepted, flush asserted at iteration 10 -> busy=0 next edge, no out_valid. The next ALU op completes normally with correct tag.
- unit_sel=3, tag=9 -> 1-cycle result, ex_out=0, out_err=1.
- rst asserted mid-MUL and while out_valid held -> all outputs 0 next edge, in_ready=1 after rst deasserts.
